seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000, clocks per digit slot; multiple of 16, >=16.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 en  in  1  1 = scan display; 0 = display off.
REQ-005 digit_1..digit_4  in  4 each  BCD digits; digit_1 least significant/rightmost.
REQ-006 upd_req  in  1  one-cycle pulse; stage digit_1..4 and blank_lz for display.
REQ-007 blank_lz  in  1  leading-zero suppression enable, staged with upd_req.
REQ-008 brightness  in  4  PWM duty; 0 dimmest, 15 full on; sampled each cycle.
REQ-009 anode  out  4  active-low digit enables; anode[0] drives digit_1.
REQ-010 one_digit  out  4  BCD value of the active slot.
REQ-011 refresh_counter  out  2  active slot index 0..3.
REQ-012 upd_ack  out  1  one-cycle pulse when staged values become visible.
REQ-013 frame_done  out  1  one-cycle pulse at each slot 3->0 wrap.

Function
REQ-014 FSM states: OFF, SCAN; OFF->SCAN when en=1; SCAN->OFF when en=0, effective next edge.
REQ-015 In SCAN: prescale count p runs 0..PRESCALE-1; at p=PRESCALE-1, p->0 and slot advances mod 4.
REQ-016 On entering SCAN: p=0, slot=0; in OFF: p=0, slot=0 held, anode=4'b1111, one_digit=0.
REQ-017 ON_CYCLES = (brightness+1)*(PRESCALE/16); anode[slot] low iff p < ON_CYCLES, other bits high.
REQ-018 brightness=15 -> active anode low for the whole slot.
REQ-019 one_digit = shadow digit of the current slot (slot s -> shadow digit_(s+1)).
REQ-020 anode, one_digit, refresh_counter SHALL be registered, computed from next-state, mutually aligned in every cycle.
REQ-021 Leading-zero suppression (shadow blank_lz=1): slot k (k=3,2,1) anode held high if shadow digits k+1..4 are all zero; slot 0 never blanked.
REQ-022 upd_req captures digit_1..4 and blank_lz into staging, sets pending; a repeat upd_req while pending overwrites staging, single ack.
REQ-023 In SCAN, staging->shadow copy only at the edge where slot wraps 3->0; upd_ack high for the following cycle; pending cleared.
REQ-024 upd_req in the same cycle as the 3->0 wrap: that request's inputs load directly into shadow at that edge; ack follows.
REQ-025 In OFF, a pending update copies to shadow on the next edge; upd_ack follows.
REQ-026 frame_done high for the cycle after the 3->0 wrap edge; never asserted in OFF.
REQ-027 en=0 mid-frame: no partial-frame shadow update; pending preserved and applied per REQ-025.

Reset
REQ-028 rst=1: state OFF, p=0, slot=0, anode=4'b1111, one_digit=0, refresh_counter=0, upd_ack=0, frame_done=0, staging/shadow=0, blank flag=0, pending=0.
REQ-029 rst dominates en and upd_req in the same cycle; a request coincident with rst is lost.

Structure
REQ-030 Shared package seven_seg_pkg: default PRESCALE, 2-bit slot type, ANODE_OFF=4'b1111, FSM state enum.
REQ-031 One sub-module, seven_seg_prescaler: p counter and slot-advance strobe, cleared when not in SCAN.

Verification (PRESCALE=16, so ON_CYCLES=brightness+1)
REQ-032 Reset, en=1, upd_req with digits 1,2,3,4, brightness=15 -> after first wrap, one_digit sequence 1,2,3,4, anode 1110,1101,1011,0111, 16 cycles each; upd_ack once.
REQ-033 brightness=3 -> active anode low exactly 4 of 16 cycles per slot, high for the rest.
REQ-034 blank_lz=1, digits 5,0,0,0 -> anode low only in slot 0; digits 0,0,0,0 -> slot 0 still shows 0.
REQ-035 upd_req mid-frame with 9,9,9,9 -> old values shown until wrap; 9s from slot 0 of next frame; upd_ack the cycle after the wrap edge; upd_req on wrap cycle -> immediate apply.
REQ-036 en=0 mid-slot 2 -> next cycle anode=1111, refresh_counter=0, no frame_done; en=1 -> restart at slot 0, p=0.
REQ-037 rst asserted mid-frame with pending update -> all outputs at reset values next cycle; no upd_ack afterwards.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seven_seg_pkg;

  // Clocks per digit slot when the parent does not override it.
  localparam int DEFAULT_PRESCALE = 100000;

  // All anodes released (active-low enables, so all ones means dark).
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Index of the digit slot currently being driven, 0 = rightmost.
  typedef logic [1:0] slot_t;

  // Scan state machine: OFF keeps the display dark, SCAN multiplexes digits.
  typedef enum logic {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Leading-zero suppression: a slot is dark when suppression is on, it is not
  // the rightmost slot, and it and every more significant digit are zero.
  // digits is packed {digit_4, digit_3, digit_2, digit_1}.
  function automatic logic slot_blanked(input slot_t slot,
                                        input logic [15:0] digits,
                                        input logic blank);
    logic zero_above;
    zero_above = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(slot)) && (digits[4*k +: 4] != 4'd0)) zero_above = 1'b0;
    end
    return blank && (slot != 2'd0) && zero_above;
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Per-slot cycle counter. Counts 0..PRESCALE-1 while running and strobes
// slot_adv on the last count of each slot; held at zero whenever stopped.
module seven_seg_prescaler
  import seven_seg_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  localparam int PW = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [PW-1:0] p_next,
  output logic          slot_adv
);

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  // Next count: clear when stopped, wrap to zero at the end of a slot.
  always_comb begin
    p_d      = p_q + 1'b1;
    slot_adv = 1'b0;
    if (!run) begin
      p_d = '0;
    end else if (p_q == P_LAST) begin
      p_d      = '0;
      slot_adv = 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  // Exposed so the parent can register outputs from the next-state count.
  assign p_next = p_d;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with PWM brightness,
// leading-zero suppression and frame-synchronous (tear-free) digit updates.
// Outputs anode/one_digit/refresh_counter are all registered from next-state
// values so they always describe the same slot in the same cycle.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] digit_4,
  input  logic       upd_req,
  input  logic       blank_lz,
  input  logic [3:0] brightness,
  output logic [3:0] anode,
  output logic [3:0] one_digit,
  output logic [1:0] refresh_counter,
  output logic       upd_ack,
  output logic       frame_done
);

  localparam int          PW     = $clog2(PRESCALE);
  localparam int          OW     = PW + 1;
  localparam logic [31:0] STEP_U = 32'(PRESCALE / 16);

  state_t      state_q, state_d;
  slot_t       slot_q, slot_d;
  logic [15:0] stage_q, stage_d;
  logic        stage_blank_q, stage_blank_d;
  logic        pending_q, pending_d;
  logic [15:0] shadow_q, shadow_d;
  logic        shadow_blank_q, shadow_blank_d;
  logic [3:0]  anode_q, anode_d;
  logic [3:0]  one_digit_q, one_digit_d;
  logic        upd_ack_q, upd_ack_d;
  logic        frame_done_q, frame_done_d;

  logic          run;
  logic          slot_adv;
  logic [PW-1:0] p_next;
  logic          wrap;
  logic [15:0]   req_digits;
  logic [OW-1:0] on_cycles;

  // The counter only runs on cycles that stay in SCAN; entering or leaving
  // SCAN forces it to zero.
  assign run = (state_q == ST_SCAN) && en;

  seven_seg_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .p_next   (p_next),
    .slot_adv (slot_adv)
  );

  // Next state, staging/shadow update handshake and next-state outputs.
  always_comb begin
    req_digits = {digit_4, digit_3, digit_2, digit_1};
    wrap       = run && slot_adv && (slot_q == 2'd3);

    // OFF->SCAN on en=1 and SCAN->OFF on en=0 collapse to following en.
    state_d = en ? ST_SCAN : ST_OFF;
    slot_d  = run ? (slot_adv ? slot_q + 2'd1 : slot_q) : 2'd0;

    stage_d        = stage_q;
    stage_blank_d  = stage_blank_q;
    pending_d      = pending_q;
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    upd_ack_d      = 1'b0;
    frame_done_d   = wrap;

    if (wrap) begin
      // Frame boundary: a request arriving now wins over an older staged one.
      if (upd_req) begin
        stage_d        = req_digits;
        stage_blank_d  = blank_lz;
        shadow_d       = req_digits;
        shadow_blank_d = blank_lz;
        pending_d      = 1'b0;
        upd_ack_d      = 1'b1;
      end else if (pending_q) begin
        shadow_d       = stage_q;
        shadow_blank_d = stage_blank_q;
        pending_d      = 1'b0;
        upd_ack_d      = 1'b1;
      end
    end else begin
      // Display is dark in OFF, so nothing can tear: apply right away.
      if ((state_q == ST_OFF) && pending_q) begin
        shadow_d       = stage_q;
        shadow_blank_d = stage_blank_q;
        pending_d      = 1'b0;
        upd_ack_d      = 1'b1;
      end
      if (upd_req) begin
        stage_d       = req_digits;
        stage_blank_d = blank_lz;
        pending_d     = 1'b1;
      end
    end

    // PWM: the active anode is on for the first (brightness+1)/16 of a slot.
    on_cycles = OW'(({28'd0, brightness} + 32'd1) * STEP_U);

    anode_d     = ANODE_OFF;
    one_digit_d = 4'd0;
    if (state_d == ST_SCAN) begin
      one_digit_d = shadow_d[4*slot_d +: 4];
      if (({1'b0, p_next} < on_cycles) &&
          !slot_blanked(slot_d, shadow_d, shadow_blank_d)) begin
        anode_d[slot_d] = 1'b0;
      end
    end
  end

  // State, data and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_OFF;
      slot_q         <= 2'd0;
      stage_q        <= '0;
      stage_blank_q  <= 1'b0;
      pending_q      <= 1'b0;
      shadow_q       <= '0;
      shadow_blank_q <= 1'b0;
      anode_q        <= ANODE_OFF;
      one_digit_q    <= 4'd0;
      upd_ack_q      <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      stage_q        <= stage_d;
      stage_blank_q  <= stage_blank_d;
      pending_q      <= pending_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      anode_q        <= anode_d;
      one_digit_q    <= one_digit_d;
      upd_ack_q      <= upd_ack_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign anode           = anode_q;
  assign one_digit       = one_digit_q;
  assign refresh_counter = slot_q;
  assign upd_ack         = upd_ack_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with PRESCALE=16 (ON_CYCLES = brightness+1).
module tb_seven_seg_scan_ctrl;

  localparam int PRESCALE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] digit_1, digit_2, digit_3, digit_4;
  logic       upd_req;
  logic       blank_lz;
  logic [3:0] brightness;
  logic [3:0] anode;
  logic [3:0] one_digit;
  logic [1:0] refresh_counter;
  logic       upd_ack;
  logic       frame_done;

  int vectors     = 0;
  int miscompares = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .digit_1         (digit_1),
    .digit_2         (digit_2),
    .digit_3         (digit_3),
    .digit_4         (digit_4),
    .upd_req         (upd_req),
    .blank_lz        (blank_lz),
    .brightness      (brightness),
    .anode           (anode),
    .one_digit       (one_digit),
    .refresh_counter (refresh_counter),
    .upd_ack         (upd_ack),
    .frame_done      (frame_done)
  );

  // Advance one clock; inputs and samples live 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse upd_req for one cycle with the given digits (d4 is leftmost).
  task automatic post_update(input logic [3:0] d4, input logic [3:0] d3,
                             input logic [3:0] d2, input logic [3:0] d1,
                             input logic b);
    digit_4 = d4; digit_3 = d3; digit_2 = d2; digit_1 = d1;
    blank_lz = b;
    upd_req  = 1'b1;
    step();
    upd_req  = 1'b0;
  endtask

  // Step until frame_done is seen (bounded); n = cycles stepped.
  task automatic wait_frame(output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (frame_done !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL wait_frame: frame_done got %b want 1 within 200 cycles", frame_done);
    end
  endtask

  task automatic test_reset();
    logic [11:0] act;
    rst = 1'b1; en = 1'b0; upd_req = 1'b0; blank_lz = 1'b0; brightness = 4'd15;
    digit_1 = 4'd0; digit_2 = 4'd0; digit_3 = 4'd0; digit_4 = 4'd0;
    step(); step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1111_0000_00_0_0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 111100000000", act);
    end
    rst = 1'b0;
    step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1111_0000_00_0_0) begin
      miscompares++;
      $display("FAIL off_idle: got %b want 111100000000", act);
    end
  endtask

  task automatic test_basic();
    int n;
    logic [3:0]  an;
    logic [11:0] act, exp;
    en = 1'b1; brightness = 4'd15;
    post_update(4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1110_0000_00_0_0) begin
      miscompares++;
      $display("FAIL scan_entry: got %b want 111000000000", act);
    end
    wait_frame(n);
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL first_wrap_latency: got %0d want 64", n);
    end
    for (int i = 0; i < 64; i++) begin
      an = 4'b1111; an[i/16] = 1'b0;
      exp = {an, 4'(i/16 + 1), 2'(i/16), i == 0, i == 0};
      act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL basic_frame cycle %0d: got %b want %b", i, act, exp);
      end
      step();
    end
  endtask

  task automatic test_brightness();
    int n;
    logic [3:0]  an;
    logic [11:0] act, exp;
    brightness = 4'd3;
    step();
    wait_frame(n);
    for (int i = 0; i < 64; i++) begin
      an = 4'b1111;
      if ((i % 16) < 4) an[i/16] = 1'b0;
      exp = {an, 4'(i/16 + 1), 2'(i/16), 1'b0, i == 0};
      act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL pwm_b3 cycle %0d: got %b want %b", i, act, exp);
      end
      step();
    end
  endtask

  task automatic test_blank();
    int n;
    logic [11:0] act, exp;
    brightness = 4'd15;
    post_update(4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
    wait_frame(n);
    for (int i = 0; i < 64; i++) begin
      exp = {(i < 16) ? 4'b1110 : 4'b1111, (i < 16) ? 4'd5 : 4'd0, 2'(i/16), i == 0, i == 0};
      act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL blank_5000 cycle %0d: got %b want %b", i, act, exp);
      end
      step();
    end
    post_update(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    wait_frame(n);
    for (int i = 0; i < 64; i++) begin
      exp = {(i < 16) ? 4'b1110 : 4'b1111, 4'd0, 2'(i/16), i == 0, i == 0};
      act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL blank_0000 cycle %0d: got %b want %b", i, act, exp);
      end
      step();
    end
  endtask

  task automatic test_mid_frame();
    logic [11:0] act, exp;
    // Starts on a wrap cycle showing 0000 with suppression on.
    for (int i = 0; i < 20; i++) step();
    post_update(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    for (int i = 21; i < 64; i++) begin
      exp = {4'b1111, 4'd0, 2'(i/16), 1'b0, 1'b0};
      act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL mid_frame_old cycle %0d: got %b want %b", i, act, exp);
      end
      step();
    end
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1110_1001_00_1_1) begin
      miscompares++;
      $display("FAIL mid_frame_apply: got %b want 111010010011", act);
    end
    for (int i = 0; i < 63; i++) step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b0111_1001_11_0_0) begin
      miscompares++;
      $display("FAIL slot3_last: got %b want 011110011100", act);
    end
    post_update(4'd4, 4'd5, 4'd6, 4'd7, 1'b0);
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1110_0111_00_1_1) begin
      miscompares++;
      $display("FAIL wrap_cycle_req: got %b want 111001110011", act);
    end
    step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1110_0111_00_0_0) begin
      miscompares++;
      $display("FAIL after_wrap_req: got %b want 111001110000", act);
    end
  endtask

  task automatic test_disable();
    int n;
    logic [11:0] act;
    // Now at slot 0, p=1; move to slot 2, p=5.
    for (int i = 1; i < 37; i++) step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1011_0101_10_0_0) begin
      miscompares++;
      $display("FAIL slot2_pos: got %b want 101101011000", act);
    end
    post_update(4'd3, 4'd3, 4'd3, 4'd3, 1'b0);
    en = 1'b0;
    step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1111_0000_00_0_0) begin
      miscompares++;
      $display("FAIL disable_now: got %b want 111100000000", act);
    end
    step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1111_0000_00_1_0) begin
      miscompares++;
      $display("FAIL off_apply_ack: got %b want 111100000010", act);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
      vectors++;
      if (act !== 12'b1111_0000_00_0_0) begin
        miscompares++;
        $display("FAIL off_hold %0d: got %b want 111100000000", i, act);
      end
    end
    en = 1'b1;
    step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1110_0011_00_0_0) begin
      miscompares++;
      $display("FAIL reenable: got %b want 111000110000", act);
    end
    wait_frame(n);
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL reenable_latency: got %0d want 64", n);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    logic [11:0] act;
    for (int i = 0; i < 10; i++) step();
    post_update(4'd8, 4'd8, 4'd8, 4'd8, 1'b0);
    rst = 1'b1;
    digit_1 = 4'd1; digit_2 = 4'd1; digit_3 = 4'd1; digit_4 = 4'd1;
    upd_req = 1'b1;
    step();
    act = {anode, one_digit, refresh_counter, upd_ack, frame_done};
    vectors++;
    if (act !== 12'b1111_0000_00_0_0) begin
      miscompares++;
      $display("FAIL reset_mid: got %b want 111100000000", act);
    end
    rst = 1'b0; upd_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (upd_ack === 1'b1) acks++;
      vectors++;
      if (one_digit !== 4'd0) begin
        miscompares++;
        $display("FAIL post_reset_digit cycle %0d: got %0d want 0", i, one_digit);
      end
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL post_reset_ack: got %0d acks want 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_brightness();
    test_blank();
    test_mid_frame();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
